// File: rtl/rack_jtag_byte_feeder_if.sv
// Signal bundle between the control path / shifter and rack_jtag_byte_feeder.
// The feeder takes the slave modport; the environment driving it takes master.
interface rack_jtag_byte_feeder_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                wr;
   logic [7:0]          wr_dat;
   logic                flush;
   logic                enable;
   logic                clear_err;
   logic                full;
   logic [DEPTH_LOG2:0] level;
   logic                overflow;
   logic                ack_err;
   logic [15:0]         sent_count;
   logic                idle;
   logic                load;
   logic [7:0]          dat;
   logic                busy;

   modport master (
      output wr, wr_dat, flush, enable, clear_err, busy,
      input  full, level, overflow, ack_err, sent_count, idle, load, dat
   );

   modport slave (
      input  wr, wr_dat, flush, enable, clear_err, busy,
      output full, level, overflow, ack_err, sent_count, idle, load, dat
   );
endinterface

// File: rtl/rack_jtag_byte_feeder.sv
// Byte FIFO feeding the RACK JTAG byte shifter: one load pulse per byte, paced by
// the shifter's busy handshake, with a completed-byte counter and sticky error flags.
module rack_jtag_byte_feeder #(
   parameter int DEPTH_LOG2  = 4,
   parameter int ACK_TIMEOUT = 8
) (
   input logic                    clk,
   input logic                    rst,
   rack_jtag_byte_feeder_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_LOAD      = 2'd1;
   localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] level;
   logic [1:0]    state;
   logic [7:0]    ack_cnt;
   logic [7:0]    ack_cnt_next;
   logic [7:0]    dat;
   logic [15:0]   sent_count;
   logic          overflow;
   logic          ack_err;
   logic          full;
   logic          empty;
   logic          pop;
   logic          push;
   logic          drop;
   logic          ack_timeout;

   // A pop frees a slot in the same cycle, so a write to a full FIFO still lands then.
   assign level        = wptr - rptr;
   assign full         = (level == PW'(DEPTH));
   assign empty        = (level == '0);
   assign pop          = (state == ST_IDLE) && bus.enable && !empty && !bus.busy && !bus.flush;
   assign push         = bus.wr && !bus.flush && (!full || pop);
   assign drop         = bus.wr && !bus.flush && full && !pop;
   assign ack_cnt_next = ack_cnt + 8'd1;
   assign ack_timeout  = (state == ST_WAIT_ACK) && !bus.busy && (ack_cnt_next == 8'(ACK_TIMEOUT));

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr[DEPTH_LOG2-1:0]] <= bus.wr_dat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else if (bus.flush) begin
         rptr <= wptr;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
      end
   end

   // A byte that never sees busy is abandoned and not counted as sent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         ack_cnt    <= '0;
         dat        <= '0;
         sent_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  dat   <= mem[rptr[DEPTH_LOG2-1:0]];
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               ack_cnt <= '0;
               state   <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (bus.busy)        state   <= ST_WAIT_DONE;
               else if (ack_timeout) state  <= ST_IDLE;
               else                 ack_cnt <= ack_cnt_next;
            end
            ST_WAIT_DONE: begin
               if (!bus.busy) begin
                  sent_count <= sent_count + 16'd1;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         ack_err  <= 1'b0;
      end else begin
         if (drop)               overflow <= 1'b1;
         else if (bus.clear_err) overflow <= 1'b0;
         if (ack_timeout)        ack_err  <= 1'b1;
         else if (bus.clear_err) ack_err  <= 1'b0;
      end
   end

   assign bus.full       = full;
   assign bus.level      = level;
   assign bus.overflow   = overflow;
   assign bus.ack_err    = ack_err;
   assign bus.sent_count = sent_count;
   assign bus.idle       = (state == ST_IDLE) && empty;
   assign bus.load       = (state == ST_LOAD);
   assign bus.dat        = dat;
endmodule

// File: tb/tb_rack_jtag_byte_feeder.sv
// Bench for rack_jtag_byte_feeder: vector table, directed corner sequences and a
// randomized run checked against a queue model; a small shifter model drives busy.
module tb_rack_jtag_byte_feeder;
   localparam int DEPTH_LOG2  = 4;
   localparam int DEPTH       = 16;
   localparam int ACK_TIMEOUT = 8;

   typedef struct {
      logic       wr;
      logic [7:0] dat;
      logic       enable;
      logic       flush;
      logic       clear_err;
      logic       exp_full;
      logic [4:0] exp_level;
      logic       exp_overflow;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   busy_len = 4;
   int   busy_left = 0;
   logic busy_pend = 1'b0;
   int   loads;
   int   loads_total;
   vec_t vecs[20];
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] want_q[$];

   rack_jtag_byte_feeder_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

   rack_jtag_byte_feeder #(
      .DEPTH_LOG2(DEPTH_LOG2),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Shifter: busy rises the cycle after load is seen, lasts busy_len cycles
   // (0 = never acknowledges, 255 = random 1..6 per byte).
   always @(negedge clk) begin
      if (rst) begin
         bus.busy  = 1'b0;
         busy_left = 0;
         busy_pend = 1'b0;
      end else begin
         if (busy_left != 0) begin
            busy_left--;
            if (busy_left == 0) bus.busy = 1'b0;
         end
         if (busy_pend) begin
            busy_pend = 1'b0;
            if (busy_len != 0) begin
               bus.busy  = 1'b1;
               busy_left = (busy_len == 255) ? int'($urandom_range(1, 6)) : busy_len;
            end
         end
         if (bus.load) busy_pend = 1'b1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic wr, input logic [7:0] dat, input logic enable,
                                input logic flush, input logic clear_err);
      bus.wr        = wr;
      bus.wr_dat    = dat;
      bus.enable    = enable;
      bus.flush     = flush;
      bus.clear_err = clear_err;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 16; i++)
         vecs[i] = '{1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0, (i == 15), 5'(i + 1), 1'b0};
      vecs[16] = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, 5'd16, 1'b1};
      vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd16, 1'b0};
      vecs[18] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 5'd16, 1'b1};
      vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd16, 1'b0};

      do_reset();
      checkOutput("reset_full",     32'(bus.full),       0);
      checkOutput("reset_level",    32'(bus.level),      0);
      checkOutput("reset_overflow", 32'(bus.overflow),   0);
      checkOutput("reset_ack_err",  32'(bus.ack_err),    0);
      checkOutput("reset_sent",     32'(bus.sent_count), 0);
      checkOutput("reset_idle",     32'(bus.idle),       1);
      checkOutput("reset_load",     32'(bus.load),       0);
      checkOutput("reset_dat",      32'(bus.dat),        0);

      // Single byte with a 20-cycle shifter
      busy_len = 20;
      applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
      step();
      checkOutput("single_level_after_wr", 32'(bus.level), 1);
      checkOutput("single_load_early",     32'(bus.load),  0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step();
      checkOutput("single_load",       32'(bus.load),  1);
      checkOutput("single_dat",        32'(bus.dat),   32'h A5);
      checkOutput("single_level_pop",  32'(bus.level), 0);
      loads = 0;
      for (int i = 0; i < 60 && !(bus.idle && bus.sent_count == 16'd1); i++) begin
         step();
         if (bus.load) loads++;
      end
      checkOutput("single_extra_loads", loads, 0);
      checkOutput("single_sent",        32'(bus.sent_count), 1);
      checkOutput("single_idle",        32'(bus.idle), 1);
      checkOutput("single_dat_hold",    32'(bus.dat), 32'h A5);

      // Burst into a held FIFO, overflow, clear-vs-set priority
      do_reset();
      busy_len = 3;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].wr, vecs[i].dat, vecs[i].enable, vecs[i].flush, vecs[i].clear_err);
         step();
         checkOutput($sformatf("vec%0d_full", i),     32'(bus.full),     32'(vecs[i].exp_full));
         checkOutput($sformatf("vec%0d_level", i),    32'(bus.level),    32'(vecs[i].exp_level));
         checkOutput($sformatf("vec%0d_overflow", i), 32'(bus.overflow), 32'(vecs[i].exp_overflow));
      end

      // Write into a full FIFO on the same edge as the first pop
      applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      step();
      checkOutput("fullpop_level",    32'(bus.level),    16);
      checkOutput("fullpop_full",     32'(bus.full),     1);
      checkOutput("fullpop_overflow", 32'(bus.overflow), 0);
      checkOutput("fullpop_load",     32'(bus.load),     1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      got_q.delete();
      if (bus.load) got_q.push_back(bus.dat);
      for (int i = 0; i < 400 && !(bus.idle && bus.sent_count == 16'd17); i++) begin
         step();
         if (bus.load) got_q.push_back(bus.dat);
      end
      want_q.delete();
      for (int i = 1; i <= 16; i++) want_q.push_back(8'(i));
      want_q.push_back(8'h77);
      checkOutput("burst_load_count", got_q.size(), 17);
      for (int i = 0; i < 17 && i < got_q.size(); i++)
         checkOutput($sformatf("burst_order%0d", i), 32'(got_q[i]), 32'(want_q[i]));
      checkOutput("burst_sent", 32'(bus.sent_count), 17);

      // Shifter never acknowledges the first byte
      do_reset();
      busy_len = 0;
      applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 8'h4D, 1'b1, 1'b0, 1'b0);
      step();
      checkOutput("noack_load", 32'(bus.load), 1);
      checkOutput("noack_dat",  32'(bus.dat),  32'h3C);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      repeat (ACK_TIMEOUT) step();
      checkOutput("noack_err_early", 32'(bus.ack_err), 0);
      busy_len = 4;
      step();
      checkOutput("noack_err_set", 32'(bus.ack_err),    1);
      checkOutput("noack_sent",    32'(bus.sent_count), 0);
      checkOutput("noack_level",   32'(bus.level),      1);
      step();
      checkOutput("noack_next_load", 32'(bus.load), 1);
      checkOutput("noack_next_dat",  32'(bus.dat),  32'h4D);
      for (int i = 0; i < 40 && !(bus.idle && bus.sent_count == 16'd1); i++) step();
      checkOutput("noack_next_sent", 32'(bus.sent_count), 1);
      checkOutput("noack_err_sticky", 32'(bus.ack_err), 1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      step();
      checkOutput("noack_err_cleared", 32'(bus.ack_err), 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Flush with a simultaneous write while the first byte is in WAIT_DONE
      do_reset();
      busy_len = 10;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'(8'h11 + i), 1'b1, 1'b0, 1'b0);
         step();
      end
      checkOutput("flush_level_before", 32'(bus.level), 3);
      applyStimulus(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
      step();
      checkOutput("flush_level",    32'(bus.level),    0);
      checkOutput("flush_overflow", 32'(bus.overflow), 0);
      checkOutput("flush_full",     32'(bus.full),     0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      loads = 0;
      repeat (30) begin
         step();
         if (bus.load) loads++;
      end
      checkOutput("flush_no_loads", loads, 0);
      checkOutput("flush_sent",     32'(bus.sent_count), 1);
      checkOutput("flush_idle",     32'(bus.idle), 1);

      // Asynchronous reset while load is high
      do_reset();
      busy_len = 2;
      applyStimulus(1'b1, 8'h21, 1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 30 && !(bus.idle && bus.sent_count == 16'd1); i++) step();
      applyStimulus(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 8'h23, 1'b1, 1'b0, 1'b0);
      step();
      checkOutput("rstmid_load_before",  32'(bus.load),       1);
      checkOutput("rstmid_level_before", 32'(bus.level),      1);
      checkOutput("rstmid_sent_before",  32'(bus.sent_count), 1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checkOutput("rstmid_load",  32'(bus.load),       0);
      checkOutput("rstmid_level", 32'(bus.level),      0);
      checkOutput("rstmid_sent",  32'(bus.sent_count), 0);
      checkOutput("rstmid_idle",  32'(bus.idle),       1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic against an ordered byte-queue model
      do_reset();
      busy_len = 255;
      exp_q.delete();
      loads_total = 0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         logic       do_wr;
         logic       do_en;
         logic       do_fl;
         logic [7:0] b;
         if (bus.load) begin
            loads_total++;
            if (exp_q.size() == 0) checkOutput("rand_load_with_empty_model", 32'(bus.load), 0);
            else checkOutput("rand_dat", 32'(bus.dat), 32'(exp_q.pop_front()));
         end
         checkOutput("rand_level",    32'(bus.level),    exp_q.size());
         checkOutput("rand_full",     32'(bus.full),     32'(exp_q.size() == DEPTH));
         checkOutput("rand_overflow", 32'(bus.overflow), 0);
         if (cyc < 700) begin
            do_en = ($urandom_range(0, 3) != 0);
            do_fl = ($urandom_range(0, 49) == 0);
            do_wr = ($urandom_range(0, 2) != 0) && (exp_q.size() < DEPTH);
            b     = 8'($urandom);
         end else begin
            do_en = 1'b1;
            do_fl = 1'b0;
            do_wr = 1'b0;
            b     = 8'h00;
         end
         applyStimulus(do_wr, b, do_en, do_fl, 1'b0);
         if (do_fl) exp_q.delete();
         else if (do_wr) exp_q.push_back(b);
         step();
      end
      checkOutput("rand_sent",    32'(bus.sent_count), loads_total & 32'hFFFF);
      checkOutput("rand_idle",    32'(bus.idle),       1);
      checkOutput("rand_ack_err", 32'(bus.ack_err),    0);
      checkOutput("rand_drained", 32'(bus.level),      exp_q.size());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
